// File: rtl/fp_mult_arbiter.sv
// Round-robin sharing of one pipelined FP32 multiplier between two requesters, with tag routing of results.
// Define MULT_ARB_FIXED_PRIO_EN to make requester 0 always win contention (no rotating pointer).
module fp_mult_arbiter #(
   parameter int LAT = 11,
   parameter int W   = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         req0,
   input  logic         req1,
   input  logic [W-1:0] a0,
   input  logic [W-1:0] b0,
   input  logic [W-1:0] a1,
   input  logic [W-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rsp_valid0,
   output logic         rsp_valid1,
   output logic [W-1:0] rsp_data,
   output logic [W-1:0] mul_dataa,
   output logic [W-1:0] mul_datab,
   output logic         mul_clk_en,
   output logic         mul_aclr,
   input  logic [W-1:0] mul_result
);

   // Tag stage k holds the op whose operands entered the core k cycles ago;
   // stage LAT lines up with that op's result on mul_result.
   logic [LAT:0] tag_vld;
   logic [LAT:0] tag_id;
   logic         gnt_any;
   logic         flush_q;

`ifndef MULT_ARB_FIXED_PRIO_EN
   logic         last_gnt1;   // 1: requester 1 was granted most recently
`endif

   // NOTE: every variable assigned here gets a default first so no latch is inferred.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (reset && !flush) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
         gnt0 = req0;
         gnt1 = req1 & ~req0;
`else
         if (req0 && req1) begin
            gnt0 = last_gnt1;
            gnt1 = ~last_gnt1;
         end else begin
            gnt0 = req0;
            gnt1 = req1;
         end
`endif
      end
   end

   assign gnt_any    = gnt0 | gnt1;
   assign mul_clk_en = (|tag_vld) | gnt_any;
   assign mul_aclr   = ~reset | flush_q;

`ifndef MULT_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_gnt1 <= 1'b1;
      end else if (gnt_any) begin
         last_gnt1 <= gnt1;
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mul_dataa <= '0;
         mul_datab <= '0;
         flush_q   <= 1'b0;
      end else begin
         flush_q <= flush;
         if (gnt_any) begin
            mul_dataa <= gnt1 ? a1 : a0;
            mul_datab <= gnt1 ? b1 : b0;
         end
      end
   end

   // NOTE: the tag pipe is a small flop chain, not a RAM, so it is reset to drop in-flight ops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_vld <= '0;
         tag_id  <= '0;
      end else if (flush) begin
         tag_vld <= '0;
      end else begin
         tag_vld <= {tag_vld[LAT-1:0], gnt_any};
         tag_id  <= {tag_id[LAT-1:0], gnt1};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
         rsp_data   <= '0;
      end else if (flush) begin
         rsp_valid0 <= 1'b0;
         rsp_valid1 <= 1'b0;
      end else begin
         rsp_valid0 <= tag_vld[LAT] & ~tag_id[LAT];
         rsp_valid1 <= tag_vld[LAT] &  tag_id[LAT];
         if (tag_vld[LAT]) begin
            rsp_data <= mul_result;
         end
      end
   end

endmodule
